// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_encoder_loader_if                                      |
// | Description : Descriptor, instruction-memory write and status signals of   |
// |               the instruction encoder/loader.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface instr_encoder_loader_if #(
    parameter int AW = 6
);
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_kind;
    logic [3:0]    in_cond;
    logic [3:0]    in_cmd;
    logic          in_s;
    logic          in_i;
    logic          in_l;
    logic [3:0]    in_rn;
    logic [3:0]    in_rd;
    logic [11:0]   in_src2;
    logic [23:0]   in_imm24;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          imem_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    modport master (
        output start, base_addr, in_valid, in_kind, in_cond, in_cmd, in_s, in_i, in_l,
               in_rn, in_rd, in_src2, in_imm24, in_last, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code, count
    );

    modport slave (
        input  start, base_addr, in_valid, in_kind, in_cond, in_cmd, in_s, in_i, in_l,
               in_rn, in_rd, in_src2, in_imm24, in_last, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, err_code, count
    );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_encoder_loader                                         |
// | Description : Encodes field-level instruction descriptors into 32-bit      |
// |               words and writes them sequentially into instruction memory.  |
// |               Optional macro TERM_EN appends a halt word (B .) per session.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_encoder_loader #(
    parameter int AW = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_encoder_loader_if.slave bus
);
    localparam logic [AW-1:0] c_last_addr = {AW{1'b1}};
    localparam logic [AW-1:0] c_ptr_one   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   c_cnt_one   = {{AW{1'b0}}, 1'b1};
`ifdef TERM_EN
    localparam logic [31:0]   c_halt_word = 32'hEAFF_FFFE;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCEPT = 3'd1,
        S_WRITE  = 3'd2,
        S_TERM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_addr;
    logic [AW:0]   r_count;
    logic [31:0]   r_wdata;
    logic          r_last;
    logic          r_full;
    logic          r_err;
    logic          r_done;
    logic [1:0]    r_err_code;
    logic [31:0]   w_word;
    logic          w_cmd_ok;
    logic [1:0]    w_chk_code;
    logic          w_in_ready;
    logic          w_busy;
    logic          w_we;

    // Descriptor encoding and the handshake-time error check
    always_comb begin
        w_cmd_ok   = 1'b0;
        w_word     = 32'h0;
        w_chk_code = 2'b00;
        case (bus.in_cmd)
            4'b0100, 4'b0010, 4'b0000, 4'b1100,
            4'b0101, 4'b0110, 4'b0111: w_cmd_ok = 1'b1;
            default:                   w_cmd_ok = 1'b0;
        endcase
        case (bus.in_kind)
            2'b00:   w_word = {bus.in_cond, 2'b00, bus.in_i, bus.in_cmd, bus.in_s,
                               bus.in_rn, bus.in_rd, bus.in_src2};
            2'b01:   w_word = {bus.in_cond, 2'b01, 5'b01100, bus.in_l,
                               bus.in_rn, bus.in_rd, bus.in_src2};
            2'b10:   w_word = {bus.in_cond, 4'b1010, bus.in_imm24};
            default: w_word = 32'h0;
        endcase
        if (bus.in_kind == 2'b11)
            w_chk_code = 2'b10;
        else if (bus.in_kind == 2'b00 && !w_cmd_ok)
            w_chk_code = 2'b01;
        else if (r_full)
            w_chk_code = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_we       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start)
                    w_next = S_ACCEPT;
            end
            S_ACCEPT: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (bus.in_valid)
                    w_next = (w_chk_code == 2'b00) ? S_WRITE : S_ERROR;
            end
            S_WRITE: begin
                w_we   = 1'b1;
                w_busy = 1'b1;
                if (bus.imem_ready) begin
                    if (!r_last)
                        w_next = S_ACCEPT;
`ifdef TERM_EN
                    else if (r_addr == c_last_addr)
                        w_next = S_ERROR;
                    else
                        w_next = S_TERM;
`else
                    else
                        w_next = S_DONE;
`endif
                end
            end
            S_TERM: begin
                w_we   = 1'b1;
                w_busy = 1'b1;
                if (bus.imem_ready)
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The pointer saturates at the top slot; r_full remembers that slot is used
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_wdata    <= 32'h0;
            r_last     <= 1'b0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_done     <= 1'b0;
        end else begin
            r_done <= (w_next == S_DONE) && (r_state != S_DONE);
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.start) begin
                        r_ptr      <= bus.base_addr;
                        r_count    <= '0;
                        r_full     <= 1'b0;
                        r_err      <= 1'b0;
                        r_err_code <= 2'b00;
                    end
                end
                S_ACCEPT: begin
                    if (bus.in_valid) begin
                        if (w_chk_code != 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_code <= w_chk_code;
                        end else begin
                            r_addr  <= r_ptr;
                            r_wdata <= w_word;
                            r_last  <= bus.in_last;
                        end
                    end
                end
                S_WRITE, S_TERM: begin
                    if (bus.imem_ready) begin
                        r_count <= r_count + c_cnt_one;
                        if (r_ptr == c_last_addr)
                            r_full <= 1'b1;
                        else
                            r_ptr <= r_ptr + c_ptr_one;
`ifdef TERM_EN
                        if (r_state == S_WRITE && r_last) begin
                            if (r_ptr == c_last_addr) begin
                                r_err      <= 1'b1;
                                r_err_code <= 2'b11;
                            end else begin
                                r_addr  <= r_ptr + c_ptr_one;
                                r_wdata <= c_halt_word;
                            end
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = w_busy;
    assign bus.imem_we    = w_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
    assign bus.count      = r_count;
endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_encoder_loader                                      |
// | Description : Self-checking bench for instr_encoder_loader with directed   |
// |               scenarios and randomized sessions against a word model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_encoder_loader;
    localparam int AW    = 6;
    localparam int c_top = (1 << AW) - 1;
`ifdef TERM_EN
    localparam logic c_term = 1'b1;
`else
    localparam logic c_term = 1'b0;
`endif

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  cond, cmd, rn, rd;
        logic        s, i, l, last;
        logic [11:0] src2;
        logic [23:0] imm24;
    } desc_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    instr_encoder_loader_if #(.AW(AW)) bus ();
    instr_encoder_loader #(.AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time_limit_reached finished=0 expected=1");
        $fatal(1, "watchdog");
    end

    function automatic desc_t mk(input logic [1:0] kind, input logic [3:0] cond, input logic [3:0] cmd,
                                 input logic s, input logic i, input logic l, input logic [3:0] rn,
                                 input logic [3:0] rd, input logic [11:0] src2, input logic [23:0] imm24,
                                 input logic last);
        desc_t d;
        d.kind = kind; d.cond = cond; d.cmd = cmd; d.s = s; d.i = i; d.l = l;
        d.rn = rn; d.rd = rd; d.src2 = src2; d.imm24 = imm24; d.last = last;
        return d;
    endfunction

    // Reference word built from the field layout with shifts and masks
    function automatic logic [31:0] model_word(input desc_t d);
        logic [31:0] w;
        w = 32'(d.cond) << 28;
        case (d.kind)
            2'd0: w = w | (32'(d.i) << 25) | (32'(d.cmd) << 21) | (32'(d.s) << 20)
                        | (32'(d.rn) << 16) | (32'(d.rd) << 12) | 32'(d.src2);
            2'd1: w = w | 32'h0580_0000 | (32'(d.l) << 20)
                        | (32'(d.rn) << 16) | (32'(d.rd) << 12) | 32'(d.src2);
            default: w = w | 32'h0A00_0000 | 32'(d.imm24);
        endcase
        return w;
    endfunction

    function automatic logic [1:0] model_code(input desc_t d, input int next_addr);
        if (d.kind == 2'd3) return 2'b10;
        if (d.kind == 2'd0 && !(d.cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0101, 4'b0110, 4'b0111}))
            return 2'b01;
        if (next_addr > c_top) return 2'b11;
        return 2'b00;
    endfunction

    function automatic desc_t rand_desc(input logic last);
        desc_t d;
        logic [3:0] ok_cmds [7];
        ok_cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0101, 4'b0110, 4'b0111};
        d.kind  = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        d.cmd   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ok_cmds[$urandom_range(0, 6)];
        d.cond  = 4'($urandom);
        d.rn    = 4'($urandom);
        d.rd    = 4'($urandom);
        d.s     = 1'($urandom);
        d.i     = 1'($urandom);
        d.l     = 1'($urandom);
        d.src2  = 12'($urandom);
        d.imm24 = 24'($urandom);
        d.last  = last;
        return d;
    endfunction

    task automatic start_session(input logic [AW-1:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Offers one descriptor and returns on the first negedge after the handshake
    task automatic present(input desc_t d);
        int n;
        n = 0;
        bus.in_kind = d.kind; bus.in_cond = d.cond; bus.in_cmd = d.cmd; bus.in_s = d.s;
        bus.in_i = d.i; bus.in_l = d.l; bus.in_rn = d.rn; bus.in_rd = d.rd;
        bus.in_src2 = d.src2; bus.in_imm24 = d.imm24; bus.in_last = d.last;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n >= 20) begin
            n_err++;
            $display("FAIL handshake_timeout in_ready=%0b expected=1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input desc_t d, input int stall, output logic we,
                        output logic [AW-1:0] a, output logic [31:0] w);
        bus.imem_ready = (stall == 0);
        present(d);
        we = bus.imem_we;
        a  = bus.imem_addr;
        w  = bus.imem_wdata;
        if (we === 1'b1) begin
            for (int k = 0; k < stall; k++) @(negedge clk);
            bus.imem_ready = 1'b1;
            @(negedge clk);
        end
        bus.imem_ready = 1'b1;
    endtask

    task automatic drain_term(output logic we, output logic [AW-1:0] a, output logic [31:0] w);
`ifdef TERM_EN
        we = bus.imem_we;
        a  = bus.imem_addr;
        w  = bus.imem_wdata;
        @(negedge clk);
`else
        we = 1'b0;
        a  = '0;
        w  = 32'h0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if ({bus.in_ready, bus.busy, bus.imem_we, bus.done, bus.err} !== 5'b0) begin n_err++;
            $display("FAIL reset_flags got=%b expected=00000", {bus.in_ready, bus.busy, bus.imem_we, bus.done, bus.err}); end
        n_vec++; if (bus.err_code !== 2'b00 || bus.count !== '0) begin n_err++;
            $display("FAIL reset_code_count got=%0d/%0d expected=0/0", bus.err_code, bus.count); end
        n_vec++; if (bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0) begin n_err++;
            $display("FAIL reset_bus got=%0d/%h expected=0/00000000", bus.imem_addr, bus.imem_wdata); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin n_err++;
            $display("FAIL idle_no_start got=%0b/%0b expected=0/0", bus.in_ready, bus.busy); end
    endtask

    task automatic test_single_dp();
        logic we, twe; logic [AW-1:0] a, ta; logic [31:0] w, tw; int ec;
        ec = 1 + int'(c_term);
        start_session('0);
        send(mk(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1, 12'h005, 24'h0, 1'b1), 0, we, a, w);
        n_vec++; if (we !== 1'b1 || a !== '0 || w !== 32'hE282_1005) begin n_err++;
            $display("FAIL add_write got=%0b/%0d/%h expected=1/0/e2821005", we, a, w); end
        drain_term(twe, ta, tw);
        n_vec++; if (twe !== c_term) begin n_err++; $display("FAIL add_halt_we got=%0b expected=%0b", twe, c_term); end
`ifdef TERM_EN
        n_vec++; if (ta !== 6'd1 || tw !== 32'hEAFF_FFFE) begin n_err++;
            $display("FAIL add_halt_word got=%0d/%h expected=1/eafffffe", ta, tw); end
`endif
        n_vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== ec[AW:0]) begin n_err++;
            $display("FAIL add_done got=%0b/%0b/%0d expected=1/0/%0d", bus.done, bus.busy, bus.count, ec); end
        @(negedge clk);
        n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_pulse got=%0b expected=0", bus.done); end
    endtask

    task automatic test_stream();
        desc_t ds [3];
        logic [31:0] exp [3];
        logic we; logic [AW-1:0] a; logic [31:0] w; int ec;
        ds[0] = mk(2'd0, 4'hE, 4'b0010, 1'b1, 1'b0, 1'b0, 4'd4, 4'd3, 12'h005, 24'h0, 1'b0);
        ds[1] = mk(2'd1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 12'h008, 24'h0, 1'b0);
        ds[2] = mk(2'd1, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 12'h008, 24'h0, 1'b1);
        exp = '{32'hE054_3005, 32'hE591_0008, 32'hE581_0008};
        ec = 3 + int'(c_term);
        start_session('0);
        for (int j = 0; j < 3; j++) begin
            send(ds[j], 0, we, a, w);
            n_vec++; if (we !== 1'b1 || int'(a) != j || w !== exp[j]) begin n_err++;
                $display("FAIL stream_%0d got=%0b/%0d/%h expected=1/%0d/%h", j, we, a, w, j, exp[j]); end
        end
        drain_term(we, a, w);
        n_vec++; if (bus.done !== 1'b1 || bus.count !== ec[AW:0]) begin n_err++;
            $display("FAIL stream_done got=%0b/%0d expected=1/%0d", bus.done, bus.count, ec); end
    endtask

    task automatic test_branch();
        logic we; logic [AW-1:0] a; logic [31:0] w;
        start_session(6'd5);
        send(mk(2'd2, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd9, 12'h0, 24'h000002, 1'b1), 0, we, a, w);
        n_vec++; if (we !== 1'b1 || a !== 6'd5 || w !== 32'h0A00_0002) begin n_err++;
            $display("FAIL branch got=%0b/%0d/%h expected=1/5/0a000002", we, a, w); end
        drain_term(we, a, w);
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL branch_done got=%0b expected=1", bus.done); end
    endtask

    task automatic test_stall();
        desc_t d;
        logic [31:0] exp;
        logic we; logic [AW-1:0] a; logic [31:0] w;
        d   = mk(2'd0, 4'hE, 4'b1100, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 12'h003, 24'h0, 1'b0);
        exp = model_word(d);
        start_session(6'd10);
        bus.imem_ready = 1'b0;
        present(d);
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 6'd10 || bus.imem_wdata !== exp || bus.in_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_hold_%0d got=%0b/%0d/%h/%0b expected=1/10/%h/0", k, bus.imem_we,
                                  bus.imem_addr, bus.imem_wdata, bus.in_ready, exp); end
            if (k < 3) @(negedge clk);
        end
        bus.imem_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.imem_we !== 1'b0 || bus.count !== 7'd1 || bus.in_ready !== 1'b1) begin n_err++;
            $display("FAIL stall_release got=%0b/%0d/%0b expected=0/1/1", bus.imem_we, bus.count, bus.in_ready); end
        start_session(6'd40);
        n_vec++; if (bus.busy !== 1'b1 || bus.count !== 7'd1) begin n_err++;
            $display("FAIL start_ignored got=%0b/%0d expected=1/1", bus.busy, bus.count); end
        d.last = 1'b1;
        send(d, 1, we, a, w);
        n_vec++; if (we !== 1'b1 || a !== 6'd11) begin n_err++; $display("FAIL stall_next got=%0b/%0d expected=1/11", we, a); end
        drain_term(we, a, w);
    endtask

    task automatic test_illegal_cmd();
        desc_t d;
        logic we; logic [AW-1:0] a; logic [31:0] w;
        start_session('0);
        send(mk(2'd0, 4'hE, 4'b1111, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 12'h1, 24'h0, 1'b1), 0, we, a, w);
        n_vec++; if (we !== 1'b0 || bus.err !== 1'b1 || bus.err_code !== 2'b01 || bus.busy !== 1'b0) begin n_err++;
            $display("FAIL bad_cmd got=%0b/%0b/%0d/%0b expected=0/1/1/0", we, bus.err, bus.err_code, bus.busy); end
        @(negedge clk);
        n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL err_sticky got=%0b expected=1", bus.err); end
        start_session(6'd3);
        n_vec++; if (bus.err !== 1'b0 || bus.err_code !== 2'b00) begin n_err++;
            $display("FAIL err_clear got=%0b/%0d expected=0/0", bus.err, bus.err_code); end
        d = mk(2'd1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd6, 12'h7F0, 24'h0, 1'b1);
        send(d, 0, we, a, w);
        n_vec++; if (we !== 1'b1 || a !== 6'd3 || w !== model_word(d)) begin n_err++;
            $display("FAIL recover got=%0b/%0d/%h expected=1/3/%h", we, a, w, model_word(d)); end
        drain_term(we, a, w);
        n_vec++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL recover_done got=%0b expected=1", bus.done); end
    endtask

    task automatic test_overflow();
        desc_t d;
        logic we; logic [AW-1:0] a; logic [31:0] w;
        d = mk(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 12'h1, 24'h0, 1'b0);
        start_session(6'd62);
        for (int j = 0; j < 3; j++) begin
            d.last = (j == 2);
            send(d, 0, we, a, w);
            if (j < 2) begin
                n_vec++; if (we !== 1'b1 || int'(a) != 62 + j) begin n_err++;
                    $display("FAIL ovf_write_%0d got=%0b/%0d expected=1/%0d", j, we, a, 62 + j); end
            end
        end
        n_vec++; if (we !== 1'b0 || bus.err !== 1'b1 || bus.err_code !== 2'b11 || bus.count !== 7'd2) begin n_err++;
            $display("FAIL ovf got=%0b/%0b/%0d/%0d expected=0/1/3/2", we, bus.err, bus.err_code, bus.count); end
        start_session(6'd63);
        d.last = 1'b0;
        send(d, 0, we, a, w);
        send(mk(2'd0, 4'hE, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h0, 24'h0, 1'b1), 0, we, a, w);
        n_vec++; if (bus.err_code !== 2'b01) begin n_err++; $display("FAIL prio_cmd_over_ovf got=%0d expected=1", bus.err_code); end
        start_session(6'd63);
        send(d, 0, we, a, w);
        send(mk(2'd3, 4'hE, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h0, 24'h0, 1'b1), 0, we, a, w);
        n_vec++; if (bus.err_code !== 2'b10) begin n_err++; $display("FAIL prio_kind got=%0d expected=2", bus.err_code); end
`ifdef TERM_EN
        start_session(6'd63);
        d.last = 1'b1;
        send(d, 0, we, a, w);
        n_vec++; if (we !== 1'b1 || bus.err !== 1'b1 || bus.err_code !== 2'b11 || bus.done !== 1'b0 || bus.count !== 7'd1) begin
            n_err++; $display("FAIL halt_ovf got=%0b/%0b/%0d/%0b/%0d expected=1/1/3/0/1", we, bus.err, bus.err_code,
                              bus.done, bus.count); end
`endif
    endtask

    task automatic test_reset_mid_write();
        start_session(6'd7);
        bus.imem_ready = 1'b0;
        present(mk(2'd2, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h0, 24'h123456, 1'b0));
        n_vec++; if (bus.imem_we !== 1'b1) begin n_err++; $display("FAIL pre_reset_we got=%0b expected=1", bus.imem_we); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++; if (bus.imem_we !== 1'b0 || bus.busy !== 1'b0 || bus.count !== '0 || bus.imem_addr !== '0) begin n_err++;
            $display("FAIL mid_reset got=%0b/%0b/%0d/%0d expected=0/0/0/0", bus.imem_we, bus.busy, bus.count, bus.imem_addr); end
        reset = 1'b0;
        bus.imem_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random();
        desc_t d;
        logic we; logic [AW-1:0] a; logic [31:0] w;
        int b, n, written, ea;
        logic [1:0] ecode;
        logic ended;
        for (int s = 0; s < 40; s++) begin
            b = ($urandom_range(0, 1) == 1) ? c_top + 1 - int'($urandom_range(1, 4)) : int'($urandom_range(0, c_top));
            n = $urandom_range(1, 5);
            written = 0;
            ended = 1'b0;
            start_session(AW'(b));
            for (int j = 0; j < n && !ended; j++) begin
                d = rand_desc(j == n - 1);
                ecode = model_code(d, b + written);
                ea = b + written;
                send(d, $urandom_range(0, 2), we, a, w);
                if (ecode != 2'b00) begin
                    ended = 1'b1;
                    n_vec++; if (we !== 1'b0 || bus.err !== 1'b1 || bus.err_code !== ecode || bus.busy !== 1'b0
                                 || bus.count !== written[AW:0]) begin n_err++;
                        $display("FAIL rnd_err s%0d got=%0b/%0b/%0d/%0d expected=0/1/%0d/%0d", s, we, bus.err,
                                 bus.err_code, bus.count, ecode, written); end
                end else begin
                    written++;
                    n_vec++; if (we !== 1'b1 || a !== ea[AW-1:0] || w !== model_word(d)) begin n_err++;
                        $display("FAIL rnd_write s%0d got=%0b/%0d/%h expected=1/%0d/%h", s, we, a, w, ea, model_word(d)); end
                end
            end
            if (!ended) begin
`ifdef TERM_EN
                ea = b + written;
                if (ea > c_top) begin
                    n_vec++; if (bus.err !== 1'b1 || bus.err_code !== 2'b11 || bus.done !== 1'b0) begin n_err++;
                        $display("FAIL rnd_halt_ovf s%0d got=%0b/%0d/%0b expected=1/3/0", s, bus.err, bus.err_code, bus.done); end
                    continue;
                end
                drain_term(we, a, w);
                written++;
                n_vec++; if (we !== 1'b1 || a !== ea[AW-1:0] || w !== 32'hEAFF_FFFE) begin n_err++;
                    $display("FAIL rnd_halt s%0d got=%0b/%0d/%h expected=1/%0d/eafffffe", s, we, a, w, ea); end
`endif
                n_vec++; if (bus.done !== 1'b1 || bus.count !== written[AW:0]) begin n_err++;
                    $display("FAIL rnd_done s%0d got=%0b/%0d expected=1/%0d", s, bus.done, bus.count, written); end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.in_kind = 2'd0;
        bus.in_cond = 4'h0; bus.in_cmd = 4'h0; bus.in_s = 1'b0; bus.in_i = 1'b0; bus.in_l = 1'b0;
        bus.in_rn = 4'h0; bus.in_rd = 4'h0; bus.in_src2 = 12'h0; bus.in_imm24 = 24'h0;
        bus.in_last = 1'b0; bus.imem_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_dp();
        test_stream();
        test_branch();
        test_stall();
        test_illegal_cmd();
        test_overflow();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
